// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
//   state_t  : controller states
//   result_t : one-hot compare result {GRE, LES, EQU}
//   nchunk() : number of slices per operand
//   cfg_ok() : legality of a WIDTH/CHUNK pair, used as an elaboration check
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit 2 = greater, bit 1 = less, bit 0 = equal.
  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    RES_EQU  = 3'b001,
    RES_LES  = 3'b010,
    RES_GRE  = 3'b100
  } result_t;

  function automatic int unsigned nchunk(input int unsigned width,
                                         input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
//   a, b     : operand slices
//   flip_msb : invert the slice MSBs first (offset-binary view of a signed top slice)
//   gt/lt/eq : a > b, a < b, a == b after the optional flip
module chunk_compare #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic [CHUNK-1:0] msb_mask;
  logic [CHUNK-1:0] a_adj;
  logic [CHUNK-1:0] b_adj;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_mask = CHUNK'(flip_msb) << (CHUNK - 1);
  assign a_adj    = a ^ msb_mask;
  assign b_adj    = b ^ msb_mask;

  assign gt = (a_adj >  b_adj);
  assign lt = (a_adj <  b_adj);
  assign eq = (a_adj == b_adj);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, one CHUNK-bit slice per clock,
// terminating at the first differing slice; cascade bits resolve equality.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (A, B, Signed, cascadeG/L/E)
//   abort                 : cancels the operation in flight
//   out_valid / out_ready : result handshake (Gre, Les, Equ, one-hot)
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  input  logic             cascadeG,
  input  logic             cascadeL,
  input  logic             cascadeE,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Gre,
  output logic             Les,
  output logic             Equ
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  generate
    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
      $error("seq_magnitude_comparator: WIDTH must be a nonzero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [2:0]       cas_q;          // {G, L, E}
  result_t          res_q, res_d;
  logic             valid_q, valid_d;
  logic             load;
  logic             alive_q;        // low only while reset holds, keeps in_ready low then

  logic [CHUNK-1:0] a_slice, b_slice;
  logic             flip_msb;
  logic             s_gt, s_lt, s_eq;

  // Current slice selection; the top slice of a signed compare is flipped.
  assign a_slice  = a_q[k_q*CHUNK +: CHUNK];
  assign b_slice  = b_q[k_q*CHUNK +: CHUNK];
  assign flip_msb = sgn_q && (k_q == K_TOP);

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a        (a_slice),
    .b        (b_slice),
    .flip_msb (flip_msb),
    .gt       (s_gt),
    .lt       (s_lt),
    .eq       (s_eq)
  );

  assign in_ready  = alive_q && (state_q == IDLE) && !abort;
  assign out_valid = valid_q;
  assign Gre       = res_q[2];
  assign Les       = res_q[1];
  assign Equ       = res_q[0];

  // Next-state, slice index, result and capture control.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    res_d   = res_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          k_d     = K_TOP;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (abort) begin
          state_d = IDLE;
          res_d   = RES_NONE;
          valid_d = 1'b0;
        end else if (s_gt) begin
          res_d   = RES_GRE;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (s_lt) begin
          res_d   = RES_LES;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (k_q == '0) begin
          // Operands equal: cascade priority G > L > E, default equal.
          if (cas_q[2])      res_d = RES_GRE;
          else if (cas_q[1]) res_d = RES_LES;
          else               res_d = RES_EQU;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          res_d   = RES_NONE;
          valid_d = 1'b0;
        end else if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        res_d   = RES_NONE;
      end
    endcase
  end

  // Control state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      res_q   <= RES_NONE;
      valid_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      alive_q <= 1'b1;
    end
  end

  // Captured operands; only these copies feed the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cas_q <= '0;
    end else if (load) begin
      a_q   <= A;
      b_q   <= B;
      sgn_q <= Signed;
      cas_q <= {cascadeG, cascadeL, cascadeE};
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator at WIDTH=16, CHUNK=4.
module tb_seq_magnitude_comparator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Signed;
  logic             cascadeG;
  logic             cascadeL;
  logic             cascadeE;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic             Gre;
  logic             Les;
  logic             Equ;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Signed    (Signed),
    .cascadeG  (cascadeG),
    .cascadeL  (cascadeL),
    .cascadeE  (cascadeE),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Gre       (Gre),
    .Les       (Les),
    .Equ       (Equ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        cg;
    logic        cl;
    logic        ce;
    int          lat;
    logic [2:0]  res;   // {Gre, Les, Equ}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                        input logic cg, input logic cl, input logic ce);
    A = a; B = b; Signed = sgn;
    cascadeG = cg; cascadeL = cl; cascadeE = ce;
    in_valid = 1'b1;
    #1;
    check("accept_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs after the accept; only captured copies may matter.
    A = 16'h5A5A; B = 16'hA5A5; Signed = ~sgn;
    cascadeG = 1'b0; cascadeL = 1'b0; cascadeE = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  logic seen;

  initial begin
    // Hand-computed vectors: {A, B, Signed, cG, cL, cE, latency, {G,L,E}}
    vecs[0]  = '{16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b010};
    vecs[1]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3'b010};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'b100};
    vecs[3]  = '{16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b100};
    vecs[4]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b001};
    vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 4, 3'b100};
    vecs[6]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 4, 3'b010};
    vecs[7]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 4, 3'b001};
    vecs[8]  = '{16'h1200, 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3'b010};
    vecs[9]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3'b100};
    vecs[10] = '{16'h0050, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'b100};
    vecs[11] = '{16'hFFF0, 16'hFFF1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 3'b010};

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Signed = 1'b0;
    cascadeG = 1'b0; cascadeL = 1'b0; cascadeE = 1'b0;
    abort = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out", {28'd0, out_valid, Gre, Les, Equ}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Table-driven compares with latency and handshake
    for (int i = 0; i < 12; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].cg, vecs[i].cl, vecs[i].ce);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_flags", i), {29'd0, Gre, Les, Equ}, {29'd0, vecs[i].res});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result holds while out_ready is low
    accept(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_hold%0d", c), {27'd0, out_valid, in_ready, Gre, Les, Equ},
            {27'd0, 5'b10010});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
    check("bp_flags_kept", {29'd0, Gre, Les, Equ}, {29'd0, 3'b010});

    // Abort during the second COMPARE cycle
    accept(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    check("abort_in_ready_masked", 32'(in_ready), 32'd0);
    abort = 1'b0;
    #1;
    check("abort_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | out_valid;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // Abort in IDLE beats in_valid
    A = 16'h0001; B = 16'h0002; abort = 1'b1; in_valid = 1'b1;
    #1;
    check("abort_idle_ready", 32'(in_ready), 32'd0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check("abort_idle_no_accept", 32'(in_ready), 32'd1);

    // Abort in DONE clears the result
    accept(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(lat);
    check("abort_done_pre", {28'd0, out_valid, Gre, Les, Equ}, {28'd0, 4'b1100});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_clear", {28'd0, out_valid, Gre, Les, Equ}, 32'd0);

    // Asynchronous reset while a result is held
    accept(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(lat);
    check("rst_done_pre", {28'd0, out_valid, Gre, Les, Equ}, {28'd0, 4'b1100});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_async", {27'd0, in_ready, out_valid, Gre, Les, Equ}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-COMPARE discards the operation
    accept(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_cmp_async", {27'd0, in_ready, out_valid, Gre, Les, Equ}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | out_valid;
    end
    check("rst_cmp_no_result", 32'(seen), 32'd0);
    check("rst_cmp_idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
